id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register for the 16-bit RISC pipeline.
- Captures the decoded instruction, PC and operands from the decode stage.
- Registers the ALU operand-conditioning controls (invA, invB, Cin) so the execute-stage ALU sees them aligned with its operands.
- Handles hazard-unit stall (hold) and branch/exception flush (bubble insertion).

Parameters:
DW, 16, datapath width of PC, operands and immediate
NOP_INSTR, 16'h0800, encoding driven on ex_instr for a bubble (opcode 00001)

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  decode stage holds a real instruction
id_instr  input  16  decoded-stage instruction word
id_pc  input  DW  PC+2 of the instruction
id_rs_data  input  DW  register-file Rs read data
id_rt_data  input  DW  register-file Rt read data
id_imm  input  DW  sign/zero-extended immediate
stall  input  1  hazard unit: hold EX contents this cycle
flush  input  1  kill the instruction entering EX
id_ready  output  1  decode may advance (= ~stall)
ex_valid  output  1  EX holds a real instruction
ex_instr  output  16  registered instruction
ex_pc  output  DW  registered PC
ex_a  output  DW  registered Rs data
ex_b  output  DW  registered Rt data
ex_imm  output  DW  registered immediate
ex_invA  output  1  ALU invert operand A
ex_invB  output  1  ALU invert operand B
ex_cin  output  1  ALU carry-in

Behaviour:
- All state registers update on posedge clk.
- rst_n low (asynchronous, immediate):
  - ex_valid=0, ex_instr=NOP_INSTR.
  - ex_pc, ex_a, ex_b, ex_imm = 0.
  - ex_invA, ex_invB, ex_cin = 0.
- Reset release is synchronous to clk. The first update is the first rising edge with rst_n high.
- Control decode (combinational on id_instr, registered with the data):
  - op = id_instr[15:11], fn = id_instr[1:0].
  - SUBI (op 01001) or SUB (op 11011, fn 01): invA=1, invB=0, cin=1 (computes Rt−Rs / imm−Rs).
  - ANDNI (op 01011) or ANDN (op 11011, fn 11): invA=0, invB=1, cin=0.
  - All other encodings: invA=invB=cin=0.
  - The decoded controls are mutually exclusive. invA and invB are never both 1.
- Per-edge priority: flush > stall > load.
  - flush=1: load a bubble. ex_valid=0, ex_instr=NOP_INSTR, controls=0, data fields=0. This applies even when stall=1 in the same cycle.
  - stall=1, flush=0: all ex_* registers hold their values, including ex_valid.
  - Otherwise, id_valid=1: load all id_* fields and the decoded controls; ex_valid=1.
  - Otherwise, id_valid=0: load a bubble, same as flush.
- id_ready = ~stall, combinational. It does not depend on flush or reset.
- Latency: one cycle from ID to EX. No combinational path from id_* to ex_*.
- Back-to-back stalls hold indefinitely with no data loss. When stall deasserts, the next edge loads the current id_* values.
- Invariant: whenever ex_valid=0, ex_invA, ex_invB and ex_cin are all 0.

Optional Feature:
Macro IDEX_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0].
  - Increments by 1 on each edge where stall=1 and flush=0.
  - Saturates at 16'hFFFF; no wrap.
  - Reset to 0 by rst_n.
  - Adds input stall_cnt_clr: synchronous clear, takes priority over increment.
- Undefined: neither port exists and no counter logic is present. Pipeline behaviour is identical in both builds.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with ex_valid=1 -> ex_valid=0 and ex_instr=16'h0800 immediately, with no clock edge required.
- SUB: id_valid=1, id_instr=16'hD8E1 (op 11011, fn 01), id_rs_data=16'h0005, id_rt_data=16'h0009 -> next edge ex_invA=1, ex_invB=0, ex_cin=1, ex_a=16'h0005, ex_b=16'h0009, ex_valid=1.
- ANDNI: id_instr=16'h5905 (op 01011) -> next edge ex_invB=1, ex_invA=0, ex_cin=0. ADDI (op 01000) -> all three controls 0.
- Stall: load SUBI, then stall=1 for 3 edges while id_* changes -> ex_* unchanged for all 3 edges and id_ready=0. After stall=0, the next edge loads the new id_* values.
- Flush vs stall: stall=1 and flush=1 together with ex_valid=1 -> next edge ex_valid=0, ex_instr=16'h0800, controls 0. id_valid=0 with no stall -> same bubble.
- IDEX_STALL_CNT_EN: 5 stall edges, then 1 flush+stall edge -> stall_cnt=5. Force to 16'hFFFF, stall again -> stays 16'hFFFF. stall_cnt_clr=1 -> 0 on the next edge.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_reg
//
// ID/EX pipeline register for the 16-bit RISC pipeline. Captures the decoded
// instruction, PC, operands and immediate from the decode stage. It also
// registers the ALU operand-conditioning controls (invA, invB, cin) so that the
// execute-stage ALU sees them aligned with its operands. The hazard unit can
// hold the register (stall) and branch/exception logic can kill the incoming
// instruction (flush). A flush or an empty decode slot loads a bubble.
//
// Edge priority: flush > stall > load.
//
// Parameters
//   DW          datapath width of PC, operands and immediate
//   NOP_INSTR   encoding presented on ex_instr for a bubble
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   id_valid                decode stage holds a real instruction
//   id_instr                decoded-stage instruction word
//   id_pc                   PC+2 of the instruction
//   id_rs_data, id_rt_data  register-file read data
//   id_imm                  extended immediate
//   stall                   hold EX contents this cycle
//   flush                   kill the instruction entering EX
//   id_ready                decode may advance (= ~stall)
//   ex_valid                EX holds a real instruction
//   ex_instr, ex_pc         registered instruction and PC
//   ex_a, ex_b, ex_imm      registered Rs data, Rt data and immediate
//   ex_invA, ex_invB        ALU invert operand A / operand B
//   ex_cin                  ALU carry-in
//
// Optional build feature (macro IDEX_STALL_CNT_EN)
//   stall_cnt_clr           synchronous clear of the stall counter
//   stall_cnt               saturating count of edges that held the register
// -----------------------------------------------------------------------------
module id_ex_pipe_reg #(
  parameter int          DW        = 16,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [15:0]   id_instr,
  input  logic [DW-1:0] id_pc,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          stall,
  input  logic          flush,
  output logic          id_ready,
  output logic          ex_valid,
  output logic [15:0]   ex_instr,
  output logic [DW-1:0] ex_pc,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_imm,
  output logic          ex_invA,
  output logic          ex_invB,
  output logic          ex_cin
`ifdef IDEX_STALL_CNT_EN
  ,
  input  logic          stall_cnt_clr,
  output logic [15:0]   stall_cnt
`endif
);

  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_ALU   = 5'b11011;
  localparam logic [1:0] FN_SUB   = 2'b01;
  localparam logic [1:0] FN_ANDN  = 2'b11;

  logic [4:0] op;
  logic [1:0] fn;
  logic       dec_inv_a;
  logic       dec_inv_b;
  logic       dec_cin;
  logic       load_bubble;

  assign op = id_instr[15:11];
  assign fn = id_instr[1:0];

  // Subtract computes Rt - Rs (or imm - Rs) as ~A + B + 1; and-not masks with ~B.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    dec_inv_a = 1'b0;
    dec_inv_b = 1'b0;
    dec_cin   = 1'b0;
    if (op == OP_SUBI || (op == OP_ALU && fn == FN_SUB)) begin
      dec_inv_a = 1'b1;
      dec_cin   = 1'b1;
    end else if (op == OP_ANDNI || (op == OP_ALU && fn == FN_ANDN)) begin
      dec_inv_b = 1'b1;
    end
  end

  // A bubble also clears the controls, so ex_valid=0 always implies idle ALU controls.
  assign load_bubble = flush || (!stall && !id_valid);
  assign id_ready    = ~stall;

  // NOTE: sequential state uses non-blocking assignments so all registers sample
  // the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_instr <= NOP_INSTR;
      ex_pc    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
      ex_invA  <= 1'b0;
      ex_invB  <= 1'b0;
      ex_cin   <= 1'b0;
    end else if (load_bubble) begin
      ex_valid <= 1'b0;
      ex_instr <= NOP_INSTR;
      ex_pc    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
      ex_invA  <= 1'b0;
      ex_invB  <= 1'b0;
      ex_cin   <= 1'b0;
    end else if (!stall) begin
      ex_valid <= 1'b1;
      ex_instr <= id_instr;
      ex_pc    <= id_pc;
      ex_a     <= id_rs_data;
      ex_b     <= id_rt_data;
      ex_imm   <= id_imm;
      ex_invA  <= dec_inv_a;
      ex_invB  <= dec_inv_b;
      ex_cin   <= dec_cin;
    end
  end

`ifdef IDEX_STALL_CNT_EN
  // Counts only edges that actually held the register; a flushed stall does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall && !flush && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_pipe_reg
//
// Directed self-checking bench for id_ex_pipe_reg. Inputs are driven between
// clock edges and outputs are sampled 1 time unit after the rising edge.
// Expected values are hand-derived from the instruction encodings.
// When built with IDEX_STALL_CNT_EN it also exercises the stall counter.
// -----------------------------------------------------------------------------
module tb_id_ex_pipe_reg;

  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [15:0]   id_instr;
  logic [DW-1:0] id_pc;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic          stall;
  logic          flush;
  logic          id_ready;
  logic          ex_valid;
  logic [15:0]   ex_instr;
  logic [DW-1:0] ex_pc;
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;
  logic [DW-1:0] ex_imm;
  logic          ex_invA;
  logic          ex_invB;
  logic          ex_cin;
`ifdef IDEX_STALL_CNT_EN
  logic          stall_cnt_clr;
  logic [15:0]   stall_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  id_ex_pipe_reg #(.DW(DW), .NOP_INSTR(16'h0800)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_rs_data (id_rs_data),
    .id_rt_data (id_rt_data),
    .id_imm     (id_imm),
    .stall      (stall),
    .flush      (flush),
    .id_ready   (id_ready),
    .ex_valid   (ex_valid),
    .ex_instr   (ex_instr),
    .ex_pc      (ex_pc),
    .ex_a       (ex_a),
    .ex_b       (ex_b),
    .ex_imm     (ex_imm),
    .ex_invA    (ex_invA),
    .ex_invB    (ex_invB),
    .ex_cin     (ex_cin)
`ifdef IDEX_STALL_CNT_EN
    ,
    .stall_cnt_clr (stall_cnt_clr),
    .stall_cnt     (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic [15:0] rs, input logic [15:0] rt, input logic [15:0] imm);
    id_valid   = v;
    id_instr   = ins;
    id_pc      = pc;
    id_rs_data = rs;
    id_rt_data = rt;
    id_imm     = imm;
  endtask

  task automatic check_ctrl(input string tag, input logic a, input logic b, input logic c);
    check({tag, ".invA"}, {31'd0, ex_invA}, {31'd0, a});
    check({tag, ".invB"}, {31'd0, ex_invB}, {31'd0, b});
    check({tag, ".cin"},  {31'd0, ex_cin},  {31'd0, c});
  endtask

  task automatic check_bubble(input string tag);
    check({tag, ".valid"}, {31'd0, ex_valid}, 32'd0);
    check({tag, ".instr"}, {16'd0, ex_instr}, 32'h0800);
    check({tag, ".a"},     {16'd0, ex_a},     32'd0);
    check({tag, ".pc"},    {16'd0, ex_pc},    32'd0);
    check_ctrl(tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
`ifdef IDEX_STALL_CNT_EN
    stall_cnt_clr = 1'b0;
`endif

    // Reset state
    #12;
    check_bubble("reset");
    check("reset.imm", {16'd0, ex_imm}, 32'd0);
    check("reset.id_ready", {31'd0, id_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // SUB: op 11011 fn 01
    drive(1'b1, 16'hD8E1, 16'h1234, 16'h0005, 16'h0009, 16'h00AA);
    step();
    check("sub.valid", {31'd0, ex_valid}, 32'd1);
    check("sub.instr", {16'd0, ex_instr}, 32'hD8E1);
    check("sub.pc",    {16'd0, ex_pc},    32'h1234);
    check("sub.a",     {16'd0, ex_a},     32'h0005);
    check("sub.b",     {16'd0, ex_b},     32'h0009);
    check("sub.imm",   {16'd0, ex_imm},   32'h00AA);
    check_ctrl("sub", 1'b1, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle with ex_valid=1
    #2;
    rst_n = 1'b0;
    #1;
    check_bubble("async_rst");
    #1;
    rst_n = 1'b1;

    // ANDNI op 01011
    drive(1'b1, 16'h5905, 16'h0010, 16'h0001, 16'h0002, 16'h0005);
    step();
    check("andni.valid", {31'd0, ex_valid}, 32'd1);
    check_ctrl("andni", 1'b0, 1'b1, 1'b0);

    // ADDI op 01000
    drive(1'b1, 16'h4003, 16'h0012, 16'h0001, 16'h0002, 16'h0003);
    step();
    check("addi.instr", {16'd0, ex_instr}, 32'h4003);
    check_ctrl("addi", 1'b0, 1'b0, 1'b0);

    // ANDN op 11011 fn 11
    drive(1'b1, 16'hD8E3, 16'h0014, 16'h0001, 16'h0002, 16'h0000);
    step();
    check_ctrl("andn", 1'b0, 1'b1, 1'b0);

    // ADD op 11011 fn 00: same op as SUB, different fn
    drive(1'b1, 16'hD8E0, 16'h0016, 16'h0001, 16'h0002, 16'h0000);
    step();
    check_ctrl("add", 1'b0, 1'b0, 1'b0);

    // Stall: load SUBI, then hold for 3 edges while id_* changes
    drive(1'b1, 16'h4807, 16'h0100, 16'h0011, 16'h0022, 16'h0007);
    step();
    check("subi.instr", {16'd0, ex_instr}, 32'h4807);
    check_ctrl("subi", 1'b1, 1'b0, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'hD8E3, 16'h0200 + 16'(i), 16'h0033, 16'h0044, 16'h0055);
      #1;
      check("stall.id_ready", {31'd0, id_ready}, 32'd0);
      step();
      check("stall.valid", {31'd0, ex_valid}, 32'd1);
      check("stall.instr", {16'd0, ex_instr}, 32'h4807);
      check("stall.pc",    {16'd0, ex_pc},    32'h0100);
      check("stall.a",     {16'd0, ex_a},     32'h0011);
      check("stall.b",     {16'd0, ex_b},     32'h0022);
      check("stall.imm",   {16'd0, ex_imm},   32'h0007);
      check_ctrl("stall", 1'b1, 1'b0, 1'b1);
    end
    stall = 1'b0;
    #1;
    check("unstall.id_ready", {31'd0, id_ready}, 32'd1);
    step();
    check("unstall.instr", {16'd0, ex_instr}, 32'hD8E3);
    check("unstall.pc",    {16'd0, ex_pc},    32'h0202);
    check("unstall.a",     {16'd0, ex_a},     32'h0033);
    check("unstall.b",     {16'd0, ex_b},     32'h0044);
    check_ctrl("unstall", 1'b0, 1'b1, 1'b0);

    // Flush wins over stall
    stall = 1'b1;
    flush = 1'b1;
    #1;
    check("flush.id_ready", {31'd0, id_ready}, 32'd0);
    step();
    check_bubble("flush_stall");
    stall = 1'b0;
    flush = 1'b0;

    // Reload, then empty decode slot with no stall
    drive(1'b1, 16'h4801, 16'h0300, 16'h0001, 16'h0002, 16'h0003);
    step();
    check("reload.valid", {31'd0, ex_valid}, 32'd1);
    drive(1'b0, 16'h4801, 16'h0300, 16'h0001, 16'h0002, 16'h0003);
    step();
    check_bubble("id_invalid");

`ifdef IDEX_STALL_CNT_EN
    stall_cnt_clr = 1'b1;
    step();
    check("cnt.clr0", {16'd0, stall_cnt}, 32'd0);
    stall_cnt_clr = 1'b0;
    stall = 1'b1;
    repeat (5) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("cnt.five", {16'd0, stall_cnt}, 32'd5);
    stall_cnt_clr = 1'b1;
    step();
    check("cnt.clr_prio", {16'd0, stall_cnt}, 32'd0);
    stall_cnt_clr = 1'b0;
    repeat (65540) step();
    check("cnt.sat", {16'd0, stall_cnt}, 32'hFFFF);
    step();
    check("cnt.sat_hold", {16'd0, stall_cnt}, 32'hFFFF);
    stall = 1'b0;
    stall_cnt_clr = 1'b1;
    step();
    check("cnt.clr", {16'd0, stall_cnt}, 32'd0);
    stall_cnt_clr = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
